uart_tx_framer: RTL and testbench

- Parametrised next-generation UART transmitter: serialises a DATA_SIZE-bit word LSB-first as start bit, data bits, optional parity bit, then 1 or 2 stop bits.
- Adds a programmable per-bit baud period, a valid/ready handshake and a per-frame stop-bit count.
- Sits between the TX FIFO and the pad driver, replacing the fixed-rate, 1-clock-per-bit transmitter.

---
 rtl/uart_tx_framer_if.sv | 22 ++
 rtl/uart_tx_framer.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_framer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// Handshake and per-frame configuration bundle between the TX FIFO and the UART framer.
interface uart_tx_framer_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DIV_WIDTH = 16
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_SIZE-1:0] data_in;
  logic [DIV_WIDTH-1:0] baud_div;
  logic                 stop2;
  logic                 parity_odd;

  modport master (
    output tx_valid, data_in, baud_div, stop2, parity_odd,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, data_in, baud_div, stop2, parity_odd,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmitter: start, DATA_SIZE data bits LSB first, optional parity, 1 or 2 stop bits.
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_framer #(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned DIV_WIDTH      = 16,
  parameter int unsigned BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_tx_framer_if.slave    bus,
  output logic               serial_data_out,
  output logic               tx_busy,
  output logic               tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  logic [BIT_COUNT_SIZE-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0]      shift_q, shift_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      stop2_q, stop2_d;
  logic                      line_q, line_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      tick;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`else
  logic                      unused_parity_odd;
  assign unused_parity_odd = bus.parity_odd;
`endif

  assign tick = (div_cnt_q == div_q);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_cnt_d = stop_cnt_q;
    stop2_d    = stop2_q;
    line_d     = line_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    if (state_q != StIdle) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      StIdle: begin
        if (bus.tx_valid && ready_q) begin
          state_d    = StStart;
          shift_d    = bus.data_in;
          div_d      = bus.baud_div;
          stop2_d    = bus.stop2;
`ifdef UART_TX_PARITY_EN
          par_d      = (^bus.data_in) ^ bus.parity_odd;
`endif
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          line_d     = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          line_d  = shift_q[0];
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == BIT_COUNT_SIZE'(DATA_SIZE - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            line_d  = par_q;
`else
            state_d = StStop;
            line_d  = 1'b1;
`endif
          end else begin
            // Shift register keeps the next data bit at index 1 of the current word.
            bit_cnt_d = bit_cnt_q + BIT_COUNT_SIZE'(1);
            shift_d   = shift_q >> 1;
            line_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop;
          line_d  = 1'b1;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (stop_cnt_q == stop2_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        div_cnt_d = '0;
        line_d    = 1'b1;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_cnt_q  <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      stop_cnt_q <= 1'b0;
      stop2_q    <= 1'b0;
      line_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      stop_cnt_q <= stop_cnt_d;
      stop2_q    <= stop2_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign bus.tx_ready    = ready_q;
  assign serial_data_out = line_q;
  assign tx_busy         = busy_q;
  assign tx_done         = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer; checks {line, busy, ready, done} every cycle of each frame.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic serial_data_out;
  logic tx_busy;
  logic tx_done;
  int   n_checks;
  int   n_errors;

  uart_tx_framer_if #(.DATA_SIZE(8), .DIV_WIDTH(16)) bus_if ();

  uart_tx_framer #(
    .DATA_SIZE(8),
    .DIV_WIDTH(16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus_if.slave),
    .serial_data_out (serial_data_out),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] status();
    return {serial_data_out, tx_busy, bus_if.tx_ready, tx_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and return #1 after the handshake edge (first start-bit cycle).
  task automatic start_hs(input logic [7:0] d, input logic [15:0] div, input logic st2,
                          input logic odd);
    int waited;
    bus_if.data_in    = d;
    bus_if.baud_div   = div;
    bus_if.stop2      = st2;
    bus_if.parity_odd = odd;
    bus_if.tx_valid   = 1'b1;
    waited = 0;
    while (!bus_if.tx_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!bus_if.tx_ready) check("ready_timeout", 32'd0, 32'd1);
    step();
  endtask

  // Called at the first start-bit cycle; returns in the tx_done cycle.
  task automatic check_frame(input logic [7:0] d, input int div, input logic st2,
                             input logic odd);
    logic [15:0] bits;
    int          n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i]; n++;
    end
    if (ParEn) begin
      bits[n] = (^d) ^ odd; n++;
    end
    bits[n] = 1'b1; n++;
    if (st2) begin
      bits[n] = 1'b1; n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k <= div; k++) begin
        check("frame_bit", 32'(status()), 32'({bits[b], 3'b100}));
        step();
      end
    end
    check("frame_done", 32'(status()), 32'(4'b1011));
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    reset_n           = 1'b0;
    bus_if.tx_valid   = 1'b0;
    bus_if.data_in    = '0;
    bus_if.baud_div   = '0;
    bus_if.stop2      = 1'b0;
    bus_if.parity_odd = 1'b0;

    // Reset then idle.
    repeat (3) step();
    check("reset_state", 32'(status()), 32'(4'b1010));
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle", 32'(status()), 32'(4'b1010));
    end

    // Basic frame, 1 clock per bit.
    start_hs(8'hA5, 16'd0, 1'b0, 1'b0);
    bus_if.tx_valid = 1'b0;
    check_frame(8'hA5, 0, 1'b0, 1'b0);
    step();
    check("done_pulse_end", 32'(status()), 32'(4'b1010));

    // Divisor 3, two stops; mid-frame input changes must be ignored.
    start_hs(8'h00, 16'd3, 1'b1, 1'b0);
    bus_if.tx_valid = 1'b0;
    bus_if.baud_div = 16'd0;
    bus_if.data_in  = 8'hFF;
    bus_if.stop2    = 1'b0;
    check_frame(8'h00, 3, 1'b1, 1'b0);
    step();
    check("done_pulse_end2", 32'(status()), 32'(4'b1010));

    // Parity polarity (frame is 11 bits when parity is compiled in).
    start_hs(8'h07, 16'd0, 1'b0, 1'b0);
    bus_if.tx_valid = 1'b0;
    check_frame(8'h07, 0, 1'b0, 1'b0);
    step();
    start_hs(8'h07, 16'd1, 1'b0, 1'b1);
    bus_if.tx_valid = 1'b0;
    check_frame(8'h07, 1, 1'b0, 1'b1);
    step();

    // Back-to-back: valid held high, second handshake in the tx_done cycle.
    start_hs(8'h55, 16'd0, 1'b0, 1'b0);
    bus_if.data_in = 8'hAA;
    check_frame(8'h55, 0, 1'b0, 1'b0);
    step();
    bus_if.tx_valid = 1'b0;
    check_frame(8'hAA, 0, 1'b0, 1'b0);
    step();
    check("b2b_idle", 32'(status()), 32'(4'b1010));

    // Reset during data bit 3 (divisor 1: start 2 clocks, bits 0..2 six clocks).
    start_hs(8'hF0, 16'd1, 1'b0, 1'b0);
    bus_if.tx_valid = 1'b0;
    repeat (8) step();
    check("pre_reset_bit3", 32'(status()), 32'(4'b0100));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 32'(status()), 32'(4'b1010));
    step();
    check("in_reset", 32'(status()), 32'(4'b1010));
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_reset_idle", 32'(status()), 32'(4'b1010));
    end
    start_hs(8'h3C, 16'd2, 1'b1, 1'b1);
    bus_if.tx_valid = 1'b0;
    check_frame(8'h3C, 2, 1'b1, 1'b1);
    step();
    check("final_idle", 32'(status()), 32'(4'b1010));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
